// File: rtl/mem_responder.sv
// Bus-slave word memory on the multiplexed address/data system bus.
// Latches the address on ALE, serves registered reads, commits writes when nME rises.
module mem_responder #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [15:0] BASE       = 16'h0000
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic [15:0]           SysBusIn,
    output logic [15:0]           SysBusOut,
    output logic                  SysBusOe,
    input  logic                  ALE,
    input  logic                  nME,
    input  logic                  nOE,
    input  logic                  nWE,
    input  logic                  LoadEn,
    input  logic [ADDR_WIDTH-1:0] LoadAddr,
    input  logic [15:0]           LoadData,
    output logic                  Busy,
    output logic                  ProtoErr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_READ, S_WRITE, S_ERR} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             addr_q, addr_d;
    logic                    sel_q, sel_d;
    logic [15:0]             wr_data_q, wr_data_d;
    logic [15:0]             bus_out_q, bus_out_d;
    logic                    proto_err_q, proto_err_d;
    logic [15:0]             mem_q [0:DEPTH-1];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [15:0]             mem_wdata;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [15:0]             mem_rdata;
    logic                    in_range;
    logic                    viol;

    // A bus value below BASE wraps the 17-bit difference far above DEPTH.
    assign in_range  = (({1'b0, SysBusIn} - {1'b0, BASE}) < 17'(DEPTH));
    assign idx       = ADDR_WIDTH'(addr_q - BASE);
    assign mem_rdata = mem_q[idx];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wr_data_d   = wr_data_q;
        bus_out_d   = bus_out_q;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;
        mem_waddr   = idx;
        mem_wdata   = wr_data_q;
        viol        = 1'b0;

        if (state_q == S_ADDR || state_q == S_READ || state_q == S_WRITE) begin
            viol = (!nME && !nOE && !nWE) || (ALE && !nME)
                || (state_q == S_WRITE && !nOE) || (state_q == S_READ && !nWE);
        end

        case (state_q)
            S_IDLE: begin
                if (ALE) begin
                    addr_d  = SysBusIn;
                    sel_d   = in_range;
                    state_d = S_ADDR;
                end else if (LoadEn) begin
                    mem_we    = 1'b1;
                    mem_waddr = LoadAddr;
                    mem_wdata = LoadData;
                end
            end
            S_ADDR: begin
                if (viol) begin
                    state_d = S_ERR;
                end else if (ALE) begin
                    addr_d = SysBusIn;
                    sel_d  = in_range;
                end else if (!nME && !nOE && nWE) begin
                    bus_out_d = sel_q ? mem_rdata : 16'h0000;
                    state_d   = S_READ;
                end else if (!nME && nOE && !nWE) begin
                    wr_data_d = SysBusIn;
                    state_d   = S_WRITE;
                end
            end
            S_READ: begin
                if (viol) begin
                    state_d = S_ERR;
                end else if (nME) begin
                    state_d = S_IDLE;
                    if (ALE) begin
                        addr_d  = SysBusIn;
                        sel_d   = in_range;
                        state_d = S_ADDR;
                    end
                end
            end
            S_WRITE: begin
                if (viol) begin
                    state_d = S_ERR;
                end else if (nME) begin
                    mem_we  = sel_q;
                    state_d = S_IDLE;
                    if (ALE) begin
                        addr_d  = SysBusIn;
                        sel_d   = in_range;
                        state_d = S_ADDR;
                    end
                end else if (!nWE) begin
                    wr_data_d = SysBusIn;
                end
            end
            S_ERR: begin
                if (nME && !ALE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (viol) proto_err_d = 1'b1;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'h0000;
            sel_q       <= 1'b0;
            wr_data_q   <= 16'h0000;
            bus_out_q   <= 16'h0000;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wr_data_q   <= wr_data_d;
            bus_out_q   <= bus_out_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge Clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign SysBusOut = bus_out_q;
    assign SysBusOe  = (state_q == S_READ) && sel_q && !nME && !nOE;
    assign Busy      = (state_q != S_IDLE);
    assign ProtoErr  = proto_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; expected read words go through a scoreboard
// queue that a negedge monitor drains whenever the block drives the bus.
module tb_mem_responder;

    logic        Clock;
    logic        nReset;
    logic [15:0] SysBusIn;
    logic [15:0] SysBusOut;
    logic        SysBusOe;
    logic        ALE, nME, nOE, nWE;
    logic        LoadEn;
    logic [7:0]  LoadAddr;
    logic [15:0] LoadData;
    logic        Busy;
    logic        ProtoErr;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q [$];

    mem_responder #(.ADDR_WIDTH(8), .BASE(16'h0000)) dut (
        .Clock(Clock), .nReset(nReset), .SysBusIn(SysBusIn), .SysBusOut(SysBusOut),
        .SysBusOe(SysBusOe), .ALE(ALE), .nME(nME), .nOE(nOE), .nWE(nWE),
        .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
        .Busy(Busy), .ProtoErr(ProtoErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: every cycle the block drives the bus must match the next expected word.
    initial begin
        forever begin
            @(negedge Clock);
            if (SysBusOe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_drive", SysBusOut, 16'hxxxx);
                end else begin
                    check("read_data", SysBusOut, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_bus();
        ALE = 1'b0; nME = 1'b1; nOE = 1'b1; nWE = 1'b1; LoadEn = 1'b0;
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        step();
        LoadEn = 1'b0;
    endtask

    // Three strobe cycles; drive expected in strobe cycles 2 and 3 when selected.
    task automatic bus_read(input logic [15:0] a, input logic sel, input logic [15:0] expv,
                            input logic ale_done, input logic hold_load);
        if (!ale_done) begin
            ALE = 1'b1; SysBusIn = a;
            step();
        end
        if (sel) begin
            exp_q.push_back(expv);
            exp_q.push_back(expv);
        end
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; LoadEn = hold_load;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock); #1;
            if (i == 0) begin
                check("oe_first_strobe_low", {15'd0, SysBusOe}, 16'd0);
                check("busy_in_read", {15'd0, Busy}, 16'd1);
            end
            @(posedge Clock); #1;
        end
        nME = 1'b1; nOE = 1'b1; LoadEn = 1'b0;
        @(negedge Clock); #1;
        check("oe_drops_with_nme", {15'd0, SysBusOe}, 16'd0);
        step();
        check("busy_after_read", {15'd0, Busy}, 16'd0);
        if (!sel) check("unsel_read_zero", SysBusOut, 16'h0000);
    endtask

    // Earlier strobe cycles carry ~d so only the last sampled word may commit.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d,
                             input logic b2b, input logic [15:0] next_a);
        ALE = 1'b1; SysBusIn = a;
        step();
        ALE = 1'b0; nME = 1'b0; nWE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            SysBusIn = (i == 2) ? d : ~d;
            step();
        end
        nME = 1'b1; nWE = 1'b1;
        if (b2b) begin
            ALE = 1'b1; SysBusIn = next_a;
        end
        step();
        ALE = 1'b0;
    endtask

    initial begin
        idle_bus();
        SysBusIn = 16'h0000; LoadAddr = 8'h00; LoadData = 16'h0000;
        nReset = 1'b0;
        step(); step();
        check("rst_busout", SysBusOut, 16'h0000);
        check("rst_oe", {15'd0, SysBusOe}, 16'd0);
        check("rst_busy", {15'd0, Busy}, 16'd0);
        check("rst_protoerr", {15'd0, ProtoErr}, 16'd0);
        #2 nReset = 1'b1;
        step();

        load(8'd3, 16'hBEEF);
        load(8'd0, 16'h0A0A);
        load(8'd7, 16'h5555);
        load(8'd9, 16'h9999);
        load(8'd255, 16'hFFEE);
        bus_read(16'd3, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        bus_read(16'd255, 1'b1, 16'hFFEE, 1'b0, 1'b0);

        bus_read(16'd7, 1'b1, 16'h5555, 1'b0, 1'b0);
        bus_write(16'd7, 16'h1234, 1'b0, 16'h0000);
        bus_read(16'd7, 1'b1, 16'h1234, 1'b0, 1'b0);

        bus_write(16'd9, 16'hCAFE, 1'b1, 16'd9);
        bus_read(16'd9, 1'b1, 16'hCAFE, 1'b1, 1'b0);

        bus_read(16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0);
        bus_write(16'h0100, 16'hDEAD, 1'b0, 16'h0000);
        bus_read(16'd0, 1'b1, 16'h0A0A, 1'b0, 1'b0);

        // All three strobes low in ADDR.
        ALE = 1'b1; SysBusIn = 16'd7;
        step();
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0; nWE = 1'b0; SysBusIn = 16'h7777;
        step();
        @(negedge Clock); #1;
        check("err_protoerr", {15'd0, ProtoErr}, 16'd1);
        check("err_no_drive", {15'd0, SysBusOe}, 16'd0);
        check("err_busy", {15'd0, Busy}, 16'd1);
        idle_bus();
        step();
        check("err_exit_idle", {15'd0, Busy}, 16'd0);

        // nOE falls mid-write: pending 16'h7777 must be discarded.
        ALE = 1'b1; SysBusIn = 16'd7;
        step();
        ALE = 1'b0; nME = 1'b0; nWE = 1'b0; SysBusIn = 16'h7777;
        step(); step();
        nOE = 1'b0;
        step();
        idle_bus();
        step();
        bus_read(16'd7, 1'b1, 16'h1234, 1'b0, 1'b0);
        bus_read(16'd0, 1'b1, 16'h0A0A, 1'b0, 1'b0);
        check("protoerr_sticky", {15'd0, ProtoErr}, 16'd1);

        // Reset pulled while driving.
        ALE = 1'b1; SysBusIn = 16'd3;
        step();
        exp_q.push_back(16'hBEEF);
        ALE = 1'b0; nME = 1'b0; nOE = 1'b0;
        step();
        @(negedge Clock); #2;
        check("pre_reset_oe", {15'd0, SysBusOe}, 16'd1);
        nReset = 1'b0;
        #1;
        check("reset_oe_async", {15'd0, SysBusOe}, 16'd0);
        check("reset_busy", {15'd0, Busy}, 16'd0);
        check("reset_protoerr", {15'd0, ProtoErr}, 16'd0);
        idle_bus();
        #1 nReset = 1'b1;
        step();
        bus_read(16'd3, 1'b1, 16'hBEEF, 1'b0, 1'b0);

        // ALE and LoadEn together: address wins, load dropped.
        ALE = 1'b1; SysBusIn = 16'd3; LoadEn = 1'b1; LoadAddr = 8'd3; LoadData = 16'h1111;
        step();
        LoadEn = 1'b0;
        bus_read(16'd3, 1'b1, 16'hBEEF, 1'b1, 1'b0);

        // LoadEn held while busy is ignored.
        LoadAddr = 8'd9; LoadData = 16'h2222;
        bus_read(16'd9, 1'b1, 16'hCAFE, 1'b0, 1'b1);
        bus_read(16'd9, 1'b1, 16'hCAFE, 1'b0, 1'b0);

        step(); step();
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
